tmc_onchip_mem_arbiter: RTL and testbench

//  Shares one single-port on-chip RAM (13-bit word address, 32-bit data, byte enables,
//  1-cycle read latency) between two Avalon-MM masters: m0 = Nios II data master,
//  m1 = TMC capture/DMA engine.

---
 rtl/tmc_onchip_mem_arbiter_pkg.sv | 24 ++
 rtl/tmc_onchip_mem_arbiter_if.sv | 52 +++++
 rtl/tmc_onchip_mem_arbiter_rr_pick.sv | 39 +++
 rtl/tmc_onchip_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_tmc_onchip_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmc_onchip_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tmc_memarb_pkg
// Brief    : Shared types and widths for the two-master on-chip RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package tmc_memarb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    localparam int STAT_GRANT_W = 16;
    localparam int STAT_WAIT_W  = 8;

    // A MAX_HOLD of 1 still needs a one-bit counter to keep the port legal.
    function automatic int hold_width(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmc_onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interfaces : tmc_memarb_avmm_if, tmc_memarb_mem_if
// Brief      : Avalon-MM master bus and single-port RAM bus with modports.
// Revision   : 1.0 - initial release
// ============================================================================
interface tmc_memarb_avmm_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );
    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

interface tmc_memarb_mem_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, byteenable, chipselect, write, writedata,
        input  readdata
    );
    modport slave (
        input  address, byteenable, chipselect, write, writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/tmc_onchip_mem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : tmc_memarb_rr_pick
// Brief    : Combinational round-robin grant decision with bounded hold.
// Revision : 1.0 - initial release
// ============================================================================
module tmc_memarb_rr_pick
    import tmc_memarb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 3
) (
    input  logic [1:0]        req,
    input  owner_t            owner,
    input  logic              last_m1,
    input  logic [HOLD_W-1:0] hold_cnt,
    output owner_t            winner
);

    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);

    always_comb begin
        winner = OWN_NONE;
        case (req)
            2'b01: winner = OWN_M0;
            2'b10: winner = OWN_M1;
            2'b11: begin
                case (owner)
                    OWN_M0:  winner = (hold_cnt < c_hold_last) ? OWN_M0 : OWN_M1;
                    OWN_M1:  winner = (hold_cnt < c_hold_last) ? OWN_M1 : OWN_M0;
                    default: winner = last_m1 ? OWN_M0 : OWN_M1;
                endcase
            end
            default: winner = OWN_NONE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tmc_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tmc_onchip_mem_arbiter
// Brief    : Shares one single-port RAM between two Avalon-MM masters with
//            round-robin arbitration, bounded hold and a read-return tag.
// Options  : TMC_MEMARB_STATS_EN builds grant / worst-wait statistics.
// Revision : 1.0 - initial release
// ============================================================================
module tmc_onchip_mem_arbiter
    import tmc_memarb_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    tmc_memarb_avmm_if.slave        m0,
    tmc_memarb_avmm_if.slave        m1,
    tmc_memarb_mem_if.master        mem,
    output logic [STAT_GRANT_W-1:0] stat_grants0,
    output logic [STAT_GRANT_W-1:0] stat_grants1,
    output logic [STAT_WAIT_W-1:0]  stat_maxwait
);

    localparam int                  c_hold_w    = hold_width(MAX_HOLD);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(MAX_HOLD - 1);

    owner_t              r_owner;
    logic                r_last_m1;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_tag_vld;
    logic                r_tag_m1;

    owner_t              w_winner;
    logic [1:0]          w_req;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_cs;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic [BE_W-1:0]     w_be;
    logic [DATA_W-1:0]   w_wdata;

    // Gating with reset_n keeps every master stalled and the RAM idle in reset.
    assign w_req = {m1.read | m1.write, m0.read | m0.write} & {2{reset_n}};

    tmc_memarb_rr_pick #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (c_hold_w)
    ) u_rr_pick (
        .req      (w_req),
        .owner    (r_owner),
        .last_m1  (r_last_m1),
        .hold_cnt (r_hold_cnt),
        .winner   (w_winner)
    );

    assign w_gnt0 = (w_winner == OWN_M0);
    assign w_gnt1 = (w_winner == OWN_M1);
    assign w_cs   = w_gnt0 | w_gnt1;

    always_comb begin
        w_addr  = m0.address;
        w_be    = m0.byteenable;
        w_wdata = m0.writedata;
        w_wr    = m0.write;
        if (w_gnt1) begin
            w_addr  = m1.address;
            w_be    = m1.byteenable;
            w_wdata = m1.writedata;
            w_wr    = m1.write;
        end
    end

    assign mem.address    = w_addr;
    assign mem.byteenable = w_be;
    assign mem.writedata  = w_wdata;
    assign mem.chipselect = w_cs;
    assign mem.write      = w_cs & w_wr;

    assign m0.waitrequest = ~w_gnt0;
    assign m1.waitrequest = ~w_gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner    <= OWN_NONE;
            r_last_m1  <= 1'b1;
            r_hold_cnt <= '0;
            r_tag_vld  <= 1'b0;
            r_tag_m1   <= 1'b0;
        end else begin
            r_owner <= w_winner;
            if (w_winner == OWN_NONE || w_winner != r_owner) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != c_hold_last) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            if (w_winner != OWN_NONE) begin
                r_last_m1 <= w_gnt1;
            end
            // A granted request that is not a write is a read (write wins on overlap).
            r_tag_vld <= w_cs & ~w_wr;
            r_tag_m1  <= w_gnt1;
        end
    end

    assign m0.readdatavalid = r_tag_vld & ~r_tag_m1;
    assign m1.readdatavalid = r_tag_vld &  r_tag_m1;
    assign m0.readdata      = mem.readdata;
    assign m1.readdata      = mem.readdata;

`ifdef TMC_MEMARB_STATS_EN
    logic [STAT_GRANT_W-1:0] r_grants0;
    logic [STAT_GRANT_W-1:0] r_grants1;
    logic [STAT_WAIT_W-1:0]  r_run0;
    logic [STAT_WAIT_W-1:0]  r_run1;
    logic [STAT_WAIT_W-1:0]  r_maxwait;
    logic [STAT_WAIT_W-1:0]  w_run0_nxt;
    logic [STAT_WAIT_W-1:0]  w_run1_nxt;
    logic [STAT_WAIT_W-1:0]  w_max_nxt;

    // Run lengths include the current stalled cycle so the max is never one short.
    always_comb begin
        w_run0_nxt = '0;
        w_run1_nxt = '0;
        if (w_req[0] && !w_gnt0) w_run0_nxt = (r_run0 == '1) ? r_run0 : r_run0 + 1'b1;
        if (w_req[1] && !w_gnt1) w_run1_nxt = (r_run1 == '1) ? r_run1 : r_run1 + 1'b1;
        w_max_nxt = r_maxwait;
        if (w_run0_nxt > w_max_nxt) w_max_nxt = w_run0_nxt;
        if (w_run1_nxt > w_max_nxt) w_max_nxt = w_run1_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grants0 <= '0;
            r_grants1 <= '0;
            r_run0    <= '0;
            r_run1    <= '0;
            r_maxwait <= '0;
        end else begin
            if (w_gnt0 && r_grants0 != '1) r_grants0 <= r_grants0 + 1'b1;
            if (w_gnt1 && r_grants1 != '1) r_grants1 <= r_grants1 + 1'b1;
            r_run0    <= w_run0_nxt;
            r_run1    <= w_run1_nxt;
            r_maxwait <= w_max_nxt;
        end
    end

    assign stat_grants0 = r_grants0;
    assign stat_grants1 = r_grants1;
    assign stat_maxwait = r_maxwait;
`else
    assign stat_grants0 = '0;
    assign stat_grants1 = '0;
    assign stat_maxwait = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmc_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmc_onchip_mem_arbiter
// Brief    : Self-checking bench for the two-master RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmc_onchip_mem_arbiter;
    import tmc_memarb_pkg::*;

    localparam int ADDR_W = 13, DATA_W = 32, BE_W = 4, MAX_HOLD = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tmc_memarb_avmm_if #(ADDR_W, DATA_W, BE_W) m0_if ();
    tmc_memarb_avmm_if #(ADDR_W, DATA_W, BE_W) m1_if ();
    tmc_memarb_mem_if  #(ADDR_W, DATA_W, BE_W) mem_if ();
    logic [15:0] stat_grants0, stat_grants1;
    logic [7:0]  stat_maxwait;

    tmc_onchip_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if), .mem(mem_if),
        .stat_grants0(stat_grants0), .stat_grants1(stat_grants1), .stat_maxwait(stat_maxwait)
    );

    // Single-port RAM with 1-cycle read latency
    logic [31:0] ram [8192];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (mem_if.chipselect) begin
            if (mem_if.write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_if.byteenable[b]) ram[mem_if.address][8*b +: 8] <= mem_if.writedata[8*b +: 8];
            end
            ram_q <= ram[mem_if.address];
        end
    end
    assign mem_if.readdata = ram_q;

    // Reference model state (1 = m0, 2 = m1, 0 = none)
    int          e_owner, e_last, e_hold, e_pend;
    logic [31:0] e_pend_data;
    logic [31:0] e_mem [8192];
    int          e_g0, e_g1, e_run0, e_run1, e_max;
    int          n_checks = 0, n_errors = 0;

    // Pending master transactions (held stable while stalled)
    bit          p_v[2];
    bit          p_rd[2], p_wr[2];
    logic [12:0] p_a[2];
    logic [3:0]  p_be[2];
    logic [31:0] p_d[2];

    function automatic int pick();
        bit r0 = m0_if.read | m0_if.write;
        bit r1 = m1_if.read | m1_if.write;
        if (r0 && r1) begin
            if (e_owner == 1) return (e_hold < MAX_HOLD - 1) ? 1 : 2;
            if (e_owner == 2) return (e_hold < MAX_HOLD - 1) ? 2 : 1;
            return (e_last == 2) ? 1 : 2;
        end
        if (r0) return 1;
        if (r1) return 2;
        return 0;
    endfunction

    function automatic void model_reset();
        e_owner = 0; e_last = 2; e_hold = 0; e_pend = -1;
        e_g0 = 0; e_g1 = 0; e_run0 = 0; e_run1 = 0; e_max = 0;
    endfunction

    function automatic void model_step();
        int w = pick();
        bit r0 = m0_if.read | m0_if.write;
        bit r1 = m1_if.read | m1_if.write;
        logic [12:0] a  = (w == 2) ? m1_if.address : m0_if.address;
        logic [3:0]  be = (w == 2) ? m1_if.byteenable : m0_if.byteenable;
        logic [31:0] d  = (w == 2) ? m1_if.writedata : m0_if.writedata;
        bit          wr = (w == 2) ? m1_if.write : m0_if.write;
        e_pend = -1;
        if (w != 0) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) if (be[b]) e_mem[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                e_pend = w - 1;
                e_pend_data = e_mem[a];
            end
        end
        if (w == 1 && e_g0 < 65535) e_g0++;
        if (w == 2 && e_g1 < 65535) e_g1++;
        e_run0 = (r0 && w != 1) ? ((e_run0 < 255) ? e_run0 + 1 : 255) : 0;
        e_run1 = (r1 && w != 2) ? ((e_run1 < 255) ? e_run1 + 1 : 255) : 0;
        if (e_run0 > e_max) e_max = e_run0;
        if (e_run1 > e_max) e_max = e_run1;
        if (w == 0) begin e_owner = 0; e_hold = 0; end
        else if (w != e_owner) begin e_owner = w; e_hold = 0; end
        else if (e_hold < MAX_HOLD - 1) e_hold++;
        if (w != 0) e_last = w;
    endfunction

    task automatic apply();
        m0_if.read = p_v[0] & p_rd[0];  m0_if.write = p_v[0] & p_wr[0];
        m0_if.address = p_a[0];  m0_if.byteenable = p_be[0];  m0_if.writedata = p_d[0];
        m1_if.read = p_v[1] & p_rd[1];  m1_if.write = p_v[1] & p_wr[1];
        m1_if.address = p_a[1];  m1_if.byteenable = p_be[1];  m1_if.writedata = p_d[1];
    endtask

    task automatic new_op(input int i, input bit rd_only);
        int k = rd_only ? 0 : $urandom_range(0, 9);
        p_v[i] = 1; p_rd[i] = (k < 5) || (k == 9); p_wr[i] = (k >= 5);
        p_a[i] = 13'($urandom_range(0, 15)); p_be[i] = 4'($urandom); p_d[i] = $urandom;
    endtask

    task automatic set_idle();
        p_v[0] = 0; p_v[1] = 0; apply();
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 0; set_idle();
        @(negedge clk); @(negedge clk);
        reset_n = 1; model_reset();
    endtask

    task automatic test_reset();
        p_v[0] = 1; p_rd[0] = 1; p_wr[0] = 0; p_a[0] = 13'h5; p_be[0] = 4'hF; p_d[0] = 0;
        p_v[1] = 1; p_rd[1] = 0; p_wr[1] = 1; p_a[1] = 13'h6; p_be[1] = 4'hF; p_d[1] = 1;
        apply(); #1;
        n_checks++; if (m0_if.waitrequest !== 1'b1) begin n_errors++; $display("FAIL reset_wait0: got %b expected 1", m0_if.waitrequest); end
        n_checks++; if (m1_if.waitrequest !== 1'b1) begin n_errors++; $display("FAIL reset_wait1: got %b expected 1", m1_if.waitrequest); end
        n_checks++; if (mem_if.chipselect !== 1'b0 || mem_if.write !== 1'b0) begin n_errors++; $display("FAIL reset_mem: got cs=%b wr=%b expected 0 0", mem_if.chipselect, mem_if.write); end
        n_checks++; if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin n_errors++; $display("FAIL reset_rdv: got %b%b expected 00", m0_if.readdatavalid, m1_if.readdatavalid); end
        n_checks++; if (stat_grants0 !== 16'd0 || stat_grants1 !== 16'd0 || stat_maxwait !== 8'd0) begin n_errors++; $display("FAIL reset_stats: got %h %h %h expected 0 0 0", stat_grants0, stat_grants1, stat_maxwait); end
        do_reset();
    endtask

    task automatic test_single_read();
        p_v[0] = 1; p_rd[0] = 1; p_wr[0] = 0; p_a[0] = 13'h0010; p_be[0] = 4'hF; p_d[0] = 0;
        p_v[1] = 0; apply(); #1;
        n_checks++; if (m0_if.waitrequest !== 1'b0) begin n_errors++; $display("FAIL single_wait0: got %b expected 0", m0_if.waitrequest); end
        n_checks++; if (mem_if.chipselect !== 1'b1 || mem_if.write !== 1'b0 || mem_if.address !== 13'h0010) begin n_errors++; $display("FAIL single_mem: got cs=%b wr=%b a=%h expected 1 0 0010", mem_if.chipselect, mem_if.write, mem_if.address); end
        tick(); set_idle(); #1;
        n_checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== e_mem[13'h0010]) begin n_errors++; $display("FAIL single_rdata: got v=%b d=%h expected 1 %h", m0_if.readdatavalid, m0_if.readdata, e_mem[13'h0010]); end
        n_checks++; if (m1_if.readdatavalid !== 1'b0 || m1_if.waitrequest !== 1'b1) begin n_errors++; $display("FAIL single_m1: got v=%b w=%b expected 0 1", m1_if.readdatavalid, m1_if.waitrequest); end
        tick();
    endtask

    task automatic test_contention();
        do_reset();
        p_v[0] = 0; p_v[1] = 0;
        for (int c = 0; c < 32; c++) begin
            int w;
            bit exp_m0;
            if (!p_v[0]) new_op(0, 1);
            if (!p_v[1]) new_op(1, 1);
            apply(); #1;
            exp_m0 = ((c / 8) % 2) == 0;
            w = pick();
            n_checks++; if (m0_if.waitrequest !== !exp_m0 || m1_if.waitrequest !== exp_m0) begin n_errors++; $display("FAIL contend_grant c=%0d: got w0=%b w1=%b expected %b %b", c, m0_if.waitrequest, m1_if.waitrequest, !exp_m0, exp_m0); end
            if (c > 0) begin
                n_checks++; if (m0_if.readdatavalid !== (e_pend == 0) || m1_if.readdatavalid !== (e_pend == 1) || m0_if.readdata !== e_pend_data) begin n_errors++; $display("FAIL contend_ret c=%0d: got v=%b%b d=%h expected %b%b %h", c, m1_if.readdatavalid, m0_if.readdatavalid, m0_if.readdata, e_pend == 1, e_pend == 0, e_pend_data); end
            end
            if (w == 1) p_v[0] = 0;
            if (w == 2) p_v[1] = 0;
            tick();
        end
        set_idle(); #1;
`ifdef TMC_MEMARB_STATS_EN
        n_checks++; if (stat_grants0 !== 16'd16 || stat_grants1 !== 16'd16 || stat_maxwait !== 8'd8) begin n_errors++; $display("FAIL contend_stats: got %0d %0d %0d expected 16 16 8", stat_grants0, stat_grants1, stat_maxwait); end
`else
        n_checks++; if (stat_grants0 !== 16'd0 || stat_grants1 !== 16'd0 || stat_maxwait !== 8'd0) begin n_errors++; $display("FAIL contend_stats: got %0d %0d %0d expected 0 0 0", stat_grants0, stat_grants1, stat_maxwait); end
`endif
        tick();
    endtask

    task automatic test_partial_write();
        logic [31:0] old = e_mem[13'h1FFF];
        p_v[0] = 0;
        p_v[1] = 1; p_rd[1] = 0; p_wr[1] = 1; p_a[1] = 13'h1FFF; p_be[1] = 4'b0011; p_d[1] = 32'hDEADBEEF;
        apply(); #1;
        n_checks++; if (m1_if.waitrequest !== 1'b0 || mem_if.write !== 1'b1 || mem_if.byteenable !== 4'b0011 || mem_if.writedata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL pw_write: got w=%b wr=%b be=%b d=%h expected 0 1 0011 deadbeef", m1_if.waitrequest, mem_if.write, mem_if.byteenable, mem_if.writedata); end
        tick();
        p_v[1] = 0;
        p_v[0] = 1; p_rd[0] = 1; p_wr[0] = 0; p_a[0] = 13'h1FFF; p_be[0] = 4'hF;
        apply(); #1;
        n_checks++; if (m0_if.waitrequest !== 1'b0) begin n_errors++; $display("FAIL pw_read_wait: got %b expected 0", m0_if.waitrequest); end
        tick(); set_idle(); #1;
        n_checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== {old[31:16], 16'hBEEF}) begin n_errors++; $display("FAIL pw_rdata: got v=%b d=%h expected 1 %h", m0_if.readdatavalid, m0_if.readdata, {old[31:16], 16'hBEEF}); end
        tick();
    endtask

    task automatic test_interleave();
        for (int i = 0; i <= 8; i++) begin
            int m = i % 2;
            p_v[0] = 0; p_v[1] = 0;
            if (i < 8) new_op(m, 1);
            apply(); #1;
            if (i < 8) begin
                n_checks++; if ((m == 0 ? m0_if.waitrequest : m1_if.waitrequest) !== 1'b0) begin n_errors++; $display("FAIL inter_wait i=%0d: got 1 expected 0", i); end
            end
            if (i > 0) begin
                bit ev1 = ((i - 1) % 2) == 1;
                n_checks++; if (m1_if.readdatavalid !== ev1 || m0_if.readdatavalid !== !ev1 || m0_if.readdata !== e_pend_data) begin n_errors++; $display("FAIL inter_ret i=%0d: got v=%b%b d=%h expected %b%b %h", i, m1_if.readdatavalid, m0_if.readdatavalid, m0_if.readdata, ev1, !ev1, e_pend_data); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        p_v[0] = 0;
        p_v[1] = 1; p_rd[1] = 1; p_wr[1] = 0; p_a[1] = 13'h0003; p_be[1] = 4'hF;
        apply(); #1;
        n_checks++; if (m1_if.waitrequest !== 1'b0) begin n_errors++; $display("FAIL mid_accept: got %b expected 0", m1_if.waitrequest); end
        tick();
        reset_n = 0; set_idle(); #1;
        n_checks++; if (m1_if.readdatavalid !== 1'b0) begin n_errors++; $display("FAIL mid_drop: got %b expected 0", m1_if.readdatavalid); end
        @(negedge clk);
        reset_n = 1; model_reset();
        new_op(0, 1); new_op(1, 1); apply(); #1;
        n_checks++; if (m1_if.readdatavalid !== 1'b0) begin n_errors++; $display("FAIL mid_drop_post: got %b expected 0", m1_if.readdatavalid); end
        n_checks++; if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin n_errors++; $display("FAIL mid_tie: got w0=%b w1=%b expected 0 1", m0_if.waitrequest, m1_if.waitrequest); end
        tick(); set_idle(); tick();
    endtask

    task automatic test_random();
        p_v[0] = 0; p_v[1] = 0;
        for (int c = 0; c < 400; c++) begin
            int w;
            bit wr;
            for (int i = 0; i < 2; i++) if (!p_v[i] && $urandom_range(0, 9) < 6) new_op(i, 0);
            apply(); #1;
            w = pick();
            wr = (w == 2) ? p_wr[1] : p_wr[0];
            n_checks++; if (m0_if.waitrequest !== (w != 1) || m1_if.waitrequest !== (w != 2)) begin n_errors++; $display("FAIL rnd_grant c=%0d: got w0=%b w1=%b expected %b %b", c, m0_if.waitrequest, m1_if.waitrequest, w != 1, w != 2); end
            n_checks++; if (mem_if.chipselect !== (w != 0) || mem_if.write !== (w != 0 && wr)) begin n_errors++; $display("FAIL rnd_mem c=%0d: got cs=%b wr=%b expected %b %b", c, mem_if.chipselect, mem_if.write, w != 0, w != 0 && wr); end
            if (w != 0) begin
                n_checks++; if (mem_if.address !== p_a[w-1]) begin n_errors++; $display("FAIL rnd_addr c=%0d: got %h expected %h", c, mem_if.address, p_a[w-1]); end
            end
            n_checks++; if (m0_if.readdatavalid !== (e_pend == 0) || m1_if.readdatavalid !== (e_pend == 1)) begin n_errors++; $display("FAIL rnd_rdv c=%0d: got %b%b expected %b%b", c, m1_if.readdatavalid, m0_if.readdatavalid, e_pend == 1, e_pend == 0); end
            if (e_pend >= 0) begin
                n_checks++; if ((e_pend == 0 ? m0_if.readdata : m1_if.readdata) !== e_pend_data) begin n_errors++; $display("FAIL rnd_rdata c=%0d: got %h expected %h", c, (e_pend == 0 ? m0_if.readdata : m1_if.readdata), e_pend_data); end
            end
            if (w != 0) p_v[w-1] = 0;
            tick();
        end
        set_idle(); #1;
`ifdef TMC_MEMARB_STATS_EN
        n_checks++; if (stat_grants0 !== 16'(e_g0) || stat_grants1 !== 16'(e_g1) || stat_maxwait !== 8'(e_max)) begin n_errors++; $display("FAIL rnd_stats: got %0d %0d %0d expected %0d %0d %0d", stat_grants0, stat_grants1, stat_maxwait, e_g0, e_g1, e_max); end
`endif
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            logic [31:0] v = $urandom;
            ram[i] <= v;
            e_mem[i] = v;
        end
        model_reset();
        set_idle();
        test_reset();
        test_single_read();
        test_contention();
        test_partial_write();
        test_interleave();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
